// File: rtl/pc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_irq_ctrl
// Fetch-stage program counter with a fixed-priority, vectored interrupt
// controller. Sequences normal flow (+4, up/down skips, branch, jump), traps
// into a per-line vector while saving the return address in epc, and returns
// on mret. No nesting: while a handler runs, requests wait until after mret.
//
// Ports
//   clk        in   1         clock, all state changes on the rising edge
//   reset      in   1         asynchronous active-low reset
//   stall      in   1         hold pc/epc/FSM/irq_id; trap and mret deferred
//   irq        in   NUM_IRQ   level requests, bit 0 has highest priority
//   irq_mask   in   NUM_IRQ   1 = line enabled
//   jump       in   1         load pc_target
//   pc_target  in   XLEN      jump / branch destination
//   branch     in   1         conditional branch, taken when zero_flag = 1
//   zero_flag  in   1         ALU zero
//   up         in   1         pc += UP_STEP
//   down       in   1         pc -= DOWN_STEP
//   mret       in   1         return from interrupt handler
//   pc         out  XLEN      current fetch address
//   epc        out  XLEN      saved return address
//   in_isr     out  1         handler active
//   irq_ack    out  1         one-cycle pulse on trap entry
//   irq_id     out  IDW       line being serviced, held until the next trap
// -----------------------------------------------------------------------------
module pc_irq_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned VEC_BASE     = 32'h100,
    parameter int unsigned VEC_STRIDE   = 4,
    parameter int unsigned UP_STEP      = 8,
    parameter int unsigned DOWN_STEP    = 4,
    localparam int unsigned IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               jump,
    input  logic [XLEN-1:0]    pc_target,
    input  logic               branch,
    input  logic               zero_flag,
    input  logic               up,
    input  logic               down,
    input  logic               mret,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    epc,
    output logic               in_isr,
    output logic               irq_ack,
    output logic [IDW-1:0]     irq_id
);

    typedef enum logic {ST_RUN = 1'b0, ST_ISR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic              ack_q, ack_d;
    logic [IDW-1:0]    id_q, id_d;

    logic [NUM_IRQ-1:0] pending;
    logic [IDW-1:0]     sel_id;
    logic [XLEN-1:0]    seq_next;
    logic [XLEN-1:0]    vec_addr;

    assign pending = irq & irq_mask;

    // Lowest set index wins: scan from the top down so the last hit is the
    // highest-priority line.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // All address arithmetic is XLEN wide, so overflow simply wraps.
    assign vec_addr = XLEN'(VEC_BASE) + XLEN'(sel_id) * XLEN'(VEC_STRIDE);

    // Normal next PC; a not-taken branch falls through to up/down/+4.
    always_comb begin
        if (jump || (branch && zero_flag)) begin
            seq_next = pc_target;
        end else if (up) begin
            seq_next = pc_q + XLEN'(UP_STEP);
        end else if (down) begin
            seq_next = pc_q - XLEN'(DOWN_STEP);
        end else begin
            seq_next = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        id_d    = id_q;
        ack_d   = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    // mret in RUN has no effect; only a pending request diverts.
                    if (|pending) begin
                        pc_d    = vec_addr;
                        epc_d   = seq_next;
                        id_d    = sel_id;
                        ack_d   = 1'b1;
                        state_d = ST_ISR;
                    end else begin
                        pc_d = seq_next;
                    end
                end
                ST_ISR: begin
                    // Requests are left pending; they re-trap after return.
                    if (mret) begin
                        pc_d    = epc_q;
                        state_d = ST_RUN;
                    end else begin
                        pc_d = seq_next;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= XLEN'(RESET_VECTOR);
            epc_q   <= '0;
            ack_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
        end
    end

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign in_isr  = (state_q == ST_ISR);
    assign irq_ack = ack_q;
    assign irq_id  = id_q;

endmodule
